// File: rtl/button_press_gen.sv
// button_press_gen: emits i_Count timed presses on o_Button (i_Start/i_Count/i_Abort in; o_Button/o_Busy/o_Done/o_Sent out)
module button_press_gen #(
  parameter int PRESS_CYCLES   = 3,
  parameter int RELEASE_CYCLES = 2,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Start,
  input  logic [COUNT_WIDTH-1:0] i_Count,
  input  logic                   i_Abort,
  output logic                   o_Button,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic [COUNT_WIDTH-1:0] o_Sent
);
  localparam int MAXC = PRESS_CYCLES > RELEASE_CYCLES ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int DW = $clog2(MAXC + 1);
  localparam logic [DW-1:0] PRESS_LOAD = DW'(PRESS_CYCLES - 1);
  localparam logic [DW-1:0] RELEASE_LOAD = DW'(RELEASE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PRESS, RELEASE, DONE} state_t;
  state_t state, state_n;
  logic [DW-1:0] dur, dur_n;
  logic [COUNT_WIDTH-1:0] rem, rem_n, sent, sent_n;
  logic stop, stop_n, button;
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state  <= IDLE;
      dur    <= '0;
      rem    <= '0;
      sent   <= '0;
      stop   <= 1'b0;
      button <= 1'b0;
    end else begin
      state  <= state_n;
      dur    <= dur_n;
      rem    <= rem_n;
      sent   <= sent_n;
      stop   <= stop_n;
      button <= state_n == PRESS;
    end
  end
  always_comb begin
    state_n = state;
    dur_n   = dur;
    rem_n   = rem;
    sent_n  = sent;
    stop_n  = stop;
    case (state)
      IDLE: if (i_Start) begin
        sent_n  = '0;
        stop_n  = 1'b0;
        rem_n   = i_Count;
        state_n = i_Count != '0 ? PRESS : DONE;
        dur_n   = i_Count != '0 ? PRESS_LOAD : '0;
      end
      PRESS: if (i_Abort || dur == '0) begin
        state_n = RELEASE;
        dur_n   = RELEASE_LOAD;
        sent_n  = sent + 1'b1;
        rem_n   = rem - 1'b1;
        stop_n  = stop | i_Abort;
      end else dur_n = dur - 1'b1;
      RELEASE: begin
        // an abort seen anywhere in the window (even its last cycle) ends the sequence
        stop_n = stop | i_Abort;
        if (dur == '0) begin
          state_n = rem != '0 && !stop_n ? PRESS : DONE;
          dur_n   = rem != '0 && !stop_n ? PRESS_LOAD : '0;
        end else dur_n = dur - 1'b1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    o_Button = button;
    o_Busy   = state != IDLE;
    o_Done   = state == DONE;
    o_Sent   = sent;
  end
endmodule

// File: tb/tb_button_press_gen.sv
// tb_button_press_gen: directed bench with a per-cycle expectation queue for button_press_gen
module tb_button_press_gen;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] count = '0;
  logic button, busy, done;
  logic [7:0] sent;
  int tests = 0, fails = 0;
  logic chk_en = 1'b0;
  always #5 clk = ~clk;
  button_press_gen #(.PRESS_CYCLES(3), .RELEASE_CYCLES(2), .COUNT_WIDTH(8)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Count(count), .i_Abort(abort),
    .o_Button(button), .o_Busy(busy), .o_Done(done), .o_Sent(sent)
  );
  typedef struct packed {logic b; logic busy; logic done; logic [7:0] sent;} ent_t;
  ent_t q[$], keep[$], cur, ex;
  logic [7:0] last_sent = '0;
  task automatic push(input logic b, input logic d, input logic [7:0] s);
    q.push_back(ent_t'{b, 1'b1, d, s});
  endtask
  task automatic build(input logic [7:0] n);
    for (int i = 1; i <= int'(n); i++) begin
      repeat (3) push(1'b1, 1'b0, 8'(i - 1));
      repeat (2) push(1'b0, 1'b0, 8'(i));
    end
    push(1'b0, 1'b1, n);
  endtask
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      last_sent = '0;
    end else if (q.size() == 0) begin
      if (start) build(count);
    end else begin
      cur = q.pop_front();
      last_sent = cur.sent;
      if (abort && !cur.done) begin
        if (cur.b) begin
          q.delete();
          repeat (2) push(1'b0, 1'b0, cur.sent + 8'd1);
          push(1'b0, 1'b1, cur.sent + 8'd1);
        end else begin
          keep.delete();
          while (q.size() != 0 && !q[0].b && !q[0].done) keep.push_back(q.pop_front());
          q = keep;
          push(1'b0, 1'b1, cur.sent);
        end
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    ex = q.size() != 0 ? q[0] : ent_t'{1'b0, 1'b0, 1'b0, last_sent};
    tests++;
    if ({button, busy, done, sent} !== {ex.b, ex.busy, ex.done, ex.sent}) begin
      fails++;
      $display("FAIL cycle_model t=%0t got button=%b busy=%b done=%b sent=%0d expected button=%b busy=%b done=%b sent=%0d",
               $time, button, busy, done, sent, ex.b, ex.busy, ex.done, ex.sent);
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic start_seq(input logic [7:0] n, input logic ab);
    @(negedge clk);
    start = 1'b1;
    count = n;
    abort = ab;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask
  task automatic wait_done(input string nm, input int c0, input int exp);
    int c = c0;
    while (!done && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk(nm, c, exp);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_button", int'(button), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_sent", int'(sent), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", int'(busy), 0);
    start_seq(8'd1, 1'b0);
    chk("single_first_high", int'(button), 1);
    wait_done("single_done_cycle", 1, 6);
    chk("single_sent", int'(sent), 1);
    @(negedge clk);
    chk("single_idle_busy", int'(busy), 0);
    chk("single_idle_sent_hold", int'(sent), 1);
    start_seq(8'd4, 1'b0);
    wait_done("burst_done_cycle", 1, 21);
    chk("burst_sent", int'(sent), 4);
    start_seq(8'd0, 1'b0);
    wait_done("zero_done_cycle", 1, 1);
    chk("zero_button", int'(button), 0);
    chk("zero_sent", int'(sent), 0);
    start_seq(8'd5, 1'b0);
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_press_button_low", int'(button), 0);
    chk("abort_press_sent", int'(sent), 2);
    wait_done("abort_press_done_cycle", 8, 10);
    chk("abort_press_final_sent", int'(sent), 2);
    start_seq(8'd3, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort_release_done_cycle", 5, 6);
    chk("abort_release_sent", int'(sent), 1);
    start_seq(8'd2, 1'b1);
    chk("start_with_abort_button", int'(button), 1);
    wait_done("start_with_abort_done_cycle", 1, 11);
    chk("start_with_abort_sent", int'(sent), 2);
    start_seq(8'd4, 1'b0);
    repeat (11) @(negedge clk);
    chk("midpress_button_before_reset", int'(button), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_button", int'(button), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    chk("midreset_sent", int'(sent), 0);
    rst = 1'b0;
    start = 1'b1;
    count = 8'd1;
    @(negedge clk);
    start = 1'b0;
    chk("post_reset_start_button", int'(button), 1);
    wait_done("post_reset_done_cycle", 1, 6);
    start_seq(8'd2, 1'b0);
    for (int c = 1; c < 11; c++) begin
      start = c == 4;
      count = 8'd7;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignore_start_done_pulse", int'(done), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignore_start_in_done_busy", int'(busy), 0);
    chk("ignore_start_sent", int'(sent), 2);
    @(negedge clk);
    chk("ignore_start_still_idle", int'(busy), 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL global_timeout reached at t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/button_press_gen.md
BUTTON_PRESS_GEN -- requirements
Module: button_press_gen

Interface
REQ-001 The module SHALL have parameter PRESS_CYCLES, default 3, meaning clock cycles o_Button is held high per press (legal range >= 1).
REQ-002 The module SHALL have parameter RELEASE_CYCLES, default 2, meaning clock cycles o_Button is held low after each press (legal range >= 1).
REQ-003 The module SHALL have parameter COUNT_WIDTH, default 8, meaning the width of the press-count request and of the sent counter.
REQ-004 The module SHALL have port i_Clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-005 The module SHALL have port i_Reset, input, 1, a synchronous active-high reset.
REQ-006 The module SHALL have port i_Start, input, 1, a request to begin a press sequence.
REQ-007 The module SHALL have port i_Count, input, COUNT_WIDTH, the number of presses requested, sampled with i_Start.
REQ-008 The module SHALL have port i_Abort, input, 1, a request to end the sequence early.
REQ-009 The module SHALL have port o_Button, output, 1, the emulated button level consumed by a falling-edge toggle block.
REQ-010 The module SHALL have port o_Busy, output, 1, high while a sequence is in progress.
REQ-011 The module SHALL have port o_Done, output, 1, a one-cycle completion pulse.
REQ-012 The module SHALL have port o_Sent, output, COUNT_WIDTH, the number of falling edges emitted in the current or last sequence.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, PRESS, RELEASE and DONE.
REQ-014 o_Button SHALL be registered, SHALL be 1 only in PRESS, and SHALL be glitch-free.
REQ-015 In IDLE, i_Start=1 with i_Count!=0 sampled at edge t SHALL latch i_Count as the remaining count, clear o_Sent, and enter PRESS, so that o_Button=1 and o_Busy=1 from cycle t+1.
REQ-016 In IDLE, i_Start=1 with i_Count=0 SHALL go to DONE with no o_Button activity and o_Sent cleared to 0.
REQ-017 PRESS SHALL last exactly PRESS_CYCLES cycles, then enter RELEASE; on that transition o_Sent SHALL increment by 1 and the remaining count SHALL decrement by 1.
REQ-018 RELEASE SHALL last exactly RELEASE_CYCLES cycles, then enter PRESS if the remaining count is nonzero, else enter DONE.
REQ-019 A sequence of N presses SHALL occupy exactly N*(PRESS_CYCLES+RELEASE_CYCLES) cycles from the first o_Button=1 to the DONE cycle.
REQ-020 DONE SHALL last one cycle with o_Done=1 and o_Busy=1, then return to IDLE.
REQ-021 o_Busy SHALL be high in PRESS, RELEASE and DONE, and low only in IDLE.
REQ-022 i_Start SHALL be ignored in any state other than IDLE, including DONE.
REQ-023 i_Abort in PRESS SHALL drop o_Button on the next cycle, count the edge in o_Sent, and enter RELEASE for a full RELEASE_CYCLES window, then enter DONE regardless of the remaining count.
REQ-024 i_Abort in RELEASE SHALL complete the current window and then enter DONE.
REQ-025 i_Abort in IDLE or DONE SHALL be ignored.
REQ-026 Simultaneous i_Start and i_Abort in IDLE SHALL start the sequence; i_Abort is ignored there.
REQ-027 o_Sent SHALL hold its value in IDLE until the next accepted i_Start.
REQ-028 Duration counters SHALL be sized to hold max(PRESS_CYCLES, RELEASE_CYCLES) and SHALL reload on every state entry.

Reset
REQ-029 i_Reset=1 at a rising edge SHALL force, on the next cycle, state IDLE, o_Button=0, o_Busy=0, o_Done=0, o_Sent=0, remaining count 0, and duration counters 0.
REQ-030 Reset SHALL take priority over i_Start and i_Abort, including mid-PRESS, where o_Button falls next cycle without o_Sent incrementing.

Verification (PRESS_CYCLES=3, RELEASE_CYCLES=2)
REQ-031 Single press: i_Start with i_Count=1 -> o_Button high 3 cycles, low 2, o_Done pulse on the 6th cycle, o_Sent=1, then IDLE.
REQ-032 Burst: i_Count=4 -> four 3-high/2-low pulses, o_Done exactly 20 cycles after the first high, o_Sent=4, o_Busy continuous.
REQ-033 Zero count: i_Count=0 -> o_Done pulses the next cycle, o_Button stays 0, o_Sent=0.
REQ-034 Abort in the 2nd cycle of press 2 of 5: o_Button falls next cycle, 2-cycle low, o_Done, o_Sent=2.
REQ-035 Reset mid-PRESS of press 3 of 4: all outputs 0 next cycle, and a new i_Start is accepted immediately after reset deasserts.
REQ-036 i_Start pulsed during RELEASE and during DONE -> ignored, sequence length unchanged.
